// File: rtl/sequence_counter_ctrl.sv
// Timing-sequence source for the 4-to-16 timing decoder.
// Holds the sequence counter SC and the IDLE/RUN/STEP_WAIT sequencing state,
// and drives the decoder select (sc) and enable (dec_en).
module sequence_counter_ctrl #(
  parameter int unsigned SC_W      = 4,
  parameter bit          WRAP_HALT = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            halt,
  input  logic            sc_clr,
  input  logic            step_mode,
  input  logic            step_go,
  output logic [SC_W-1:0] sc,
  output logic            dec_en,
  output logic            running,
  output logic            instr_done,
  output logic            sc_wrap
);

  localparam logic [SC_W-1:0] SC_MAX = '1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STEP_WAIT = 2'd2
  } state_t;

  state_t state;
  logic   run_q;

  // dec_en and running both mirror the registered RUN flag
  assign dec_en  = run_q;
  assign running = run_q;

  // Sequencing FSM, counter and pulse outputs; run_q tracks state==RUN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      sc         <= '0;
      run_q      <= 1'b0;
      instr_done <= 1'b0;
      sc_wrap    <= 1'b0;
    end else begin
      instr_done <= 1'b0;
      sc_wrap    <= 1'b0;
      case (state)
        IDLE: begin
          sc <= '0;
          if (start && !halt) begin
            state <= RUN;
            run_q <= 1'b1;
          end
        end
        RUN: begin
          if (halt) begin
            state <= IDLE;
            run_q <= 1'b0;
            sc    <= '0;
          end else if (sc_clr) begin
            sc         <= '0;
            instr_done <= 1'b1;
            if (step_mode) begin
              state <= STEP_WAIT;
              run_q <= 1'b0;
            end
          end else begin
            sc <= sc + SC_W'(1);
            if (sc == SC_MAX) begin
              sc_wrap <= 1'b1;
              if (WRAP_HALT) begin
                state <= IDLE;
                run_q <= 1'b0;
              end
            end
          end
        end
        STEP_WAIT: begin
          sc <= '0;
          if (halt) begin
            state <= IDLE;
            run_q <= 1'b0;
          end else if (step_go) begin
            state <= RUN;
            run_q <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          run_q <= 1'b0;
          sc    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_counter_ctrl.sv
// Directed bench for sequence_counter_ctrl; two instances cover WRAP_HALT=0/1.
module tb_sequence_counter_ctrl;

  logic clk;
  logic rst_n, start, halt, sc_clr, step_mode, step_go;
  logic [3:0] sc0, sc1;
  logic en0, run0, id0, wr0;
  logic en1, run1, id1, wr1;

  int tests = 0;
  int fails = 0;

  sequence_counter_ctrl #(.SC_W(4), .WRAP_HALT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .sc_clr(sc_clr),
    .step_mode(step_mode), .step_go(step_go),
    .sc(sc0), .dec_en(en0), .running(run0), .instr_done(id0), .sc_wrap(wr0)
  );

  sequence_counter_ctrl #(.SC_W(4), .WRAP_HALT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .sc_clr(sc_clr),
    .step_mode(step_mode), .step_go(step_go),
    .sc(sc1), .dec_en(en1), .running(run1), .instr_done(id1), .sc_wrap(wr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare all outputs of the WRAP_HALT=0 instance
  task automatic chk0(input string tag, input logic [3:0] esc, input logic een,
                      input logic eid, input logic ewr);
    chk({tag, ".sc"}, 32'(sc0), 32'(esc));
    chk({tag, ".dec_en"}, 32'(en0), 32'(een));
    chk({tag, ".running"}, 32'(run0), 32'(een));
    chk({tag, ".instr_done"}, 32'(id0), 32'(eid));
    chk({tag, ".sc_wrap"}, 32'(wr0), 32'(ewr));
  endtask

  task automatic chk1(input string tag, input logic [3:0] esc, input logic een,
                      input logic eid, input logic ewr);
    chk({tag, ".sc"}, 32'(sc1), 32'(esc));
    chk({tag, ".dec_en"}, 32'(en1), 32'(een));
    chk({tag, ".running"}, 32'(run1), 32'(een));
    chk({tag, ".instr_done"}, 32'(id1), 32'(eid));
    chk({tag, ".sc_wrap"}, 32'(wr1), 32'(ewr));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; halt = 1'b0; sc_clr = 1'b0;
    step_mode = 1'b0; step_go = 1'b0;

    // 1: reset held two cycles with start asserted
    tick(); chk0("rst_a", 4'd0, 1'b0, 1'b0, 1'b0); chk1("rst_a1", 4'd0, 1'b0, 1'b0, 1'b0);
    tick(); chk0("rst_b", 4'd0, 1'b0, 1'b0, 1'b0); chk1("rst_b1", 4'd0, 1'b0, 1'b0, 1'b0);

    // 2: start pulse, count 0..4, then sc_clr at sc=4
    rst_n = 1'b1;
    tick(); chk0("start_t0", 4'd0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick(); chk0("count", 4'(i), 1'b1, 1'b0, 1'b0);
    end
    sc_clr = 1'b1;
    tick(); chk0("clr_pulse", 4'd0, 1'b1, 1'b1, 1'b0); chk1("clr_pulse1", 4'd0, 1'b1, 1'b1, 1'b0);
    sc_clr = 1'b0;
    tick(); chk0("clr_after", 4'd1, 1'b1, 1'b0, 1'b0);

    // 3: free-run to wrap; WRAP_HALT=0 keeps running, WRAP_HALT=1 stops
    for (int i = 2; i <= 15; i++) begin
      tick(); chk0("run_up", 4'(i), 1'b1, 1'b0, 1'b0);
    end
    chk1("pre_wrap1", 4'd15, 1'b1, 1'b0, 1'b0);
    tick(); chk0("wrap", 4'd0, 1'b1, 1'b0, 1'b1); chk1("wrap1", 4'd0, 1'b0, 1'b0, 1'b1);
    tick(); chk0("post_wrap", 4'd1, 1'b1, 1'b0, 1'b0); chk1("post_wrap1", 4'd0, 1'b0, 1'b0, 1'b0);

    // 4: halt and sc_clr together at sc=3
    tick(); tick(); chk0("at3", 4'd3, 1'b1, 1'b0, 1'b0);
    halt = 1'b1; sc_clr = 1'b1;
    tick(); chk0("halt_clr", 4'd0, 1'b0, 1'b0, 1'b0);
    halt = 1'b0; sc_clr = 1'b0;
    tick(); chk0("idle_hold", 4'd0, 1'b0, 1'b0, 1'b0);

    // 5: step mode, sc_clr at sc=5, wait 10 cycles, step_go resumes at T0
    start = 1'b1; step_mode = 1'b1;
    tick(); chk0("step_start", 4'd0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk0("at5", 4'd5, 1'b1, 1'b0, 1'b0);
    sc_clr = 1'b1;
    tick(); chk0("step_clr", 4'd0, 1'b0, 1'b1, 1'b0);
    sc_clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) step_mode = 1'b0;
      tick(); chk0("step_wait", 4'd0, 1'b0, 1'b0, 1'b0);
    end
    step_go = 1'b1;
    tick(); chk0("step_go", 4'd0, 1'b1, 1'b0, 1'b0);
    step_go = 1'b0;
    tick(); chk0("step_resume", 4'd1, 1'b1, 1'b0, 1'b0);

    // 6: reset mid-instruction at sc=7, then restart
    for (int i = 0; i < 6; i++) tick();
    chk0("at7", 4'd7, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick(); chk0("mid_rst", 4'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick(); chk0("rst_idle", 4'd0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    tick(); chk0("restart_t0", 4'd0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    tick(); chk0("restart_t1", 4'd1, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
